// File: rtl/simmem_delay_releaser.sv
// Per-ID release scheduler: holds delay requests in slots and raises release_en per expired ID.
// Optional sticky spurious-release flag on err_o when SIMMEM_RELEASER_ERR_EN is defined.
module simmem_delay_releaser #(
  parameter int unsigned IDWidth    = 4,
  parameter int unsigned NumSlots   = 8,
  parameter int unsigned DelayWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [IDWidth-1:0]      in_id_i,
  input  logic [DelayWidth-1:0]   in_delay_i,
  output logic [2**IDWidth-1:0]   release_en_o,
  input  logic                    rel_done_i,
  input  logic [IDWidth-1:0]      rel_id_i,
  output logic                    err_o
);

  typedef enum logic [1:0] {
    SlotFree     = 2'd0,
    SlotCounting = 2'd1,
    SlotExpired  = 2'd2
  } slot_state_e;

  slot_state_e             state_q [NumSlots];
  slot_state_e             state_d [NumSlots];
  logic [IDWidth-1:0]      id_q    [NumSlots];
  logic [IDWidth-1:0]      id_d    [NumSlots];
  logic [DelayWidth-1:0]   cnt_q   [NumSlots];
  logic [DelayWidth-1:0]   cnt_d   [NumSlots];
  logic                    alloc_done;
  logic                    retire_hit;

  // Slot registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < NumSlots; s++) begin
        state_q[s] <= SlotFree;
        id_q[s]    <= '0;
        cnt_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count, retire and allocate; retire and allocate both look only at registered
  // state, so a slot freed this cycle cannot be reallocated until the next one.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    alloc_done = 1'b0;
    retire_hit = 1'b0;
    for (int unsigned s = 0; s < NumSlots; s++) begin
      if (state_q[s] == SlotCounting) begin
        if (cnt_q[s] > DelayWidth'(1)) begin
          cnt_d[s] = cnt_q[s] - DelayWidth'(1);
        end else begin
          state_d[s] = SlotExpired;
          cnt_d[s]   = '0;
        end
      end
      if (rel_done_i && !retire_hit && (state_q[s] == SlotExpired) &&
          (id_q[s] == rel_id_i)) begin
        state_d[s] = SlotFree;
        retire_hit = 1'b1;
      end
      if (in_valid_i && !alloc_done && (state_q[s] == SlotFree)) begin
        alloc_done = 1'b1;
        id_d[s]    = in_id_i;
        if (in_delay_i == '0) begin
          state_d[s] = SlotExpired;
          cnt_d[s]   = '0;
        end else begin
          state_d[s] = SlotCounting;
          cnt_d[s]   = in_delay_i;
        end
      end
    end
  end

  // Release vector and ready, from registered state only
  always_comb begin
    release_en_o = '0;
    in_ready_o   = 1'b0;
    for (int unsigned s = 0; s < NumSlots; s++) begin
      if (state_q[s] == SlotExpired) begin
        release_en_o[id_q[s]] = 1'b1;
      end
      if (state_q[s] == SlotFree) begin
        in_ready_o = 1'b1;
      end
    end
  end

`ifdef SIMMEM_RELEASER_ERR_EN
  logic err_q;
  logic err_d;

  assign err_d = err_q | (rel_done_i & ~retire_hit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
